// File: rtl/fp_vector_accumulator.sv
// Streaming FP vector reduction: rotates partial sums over ADD_LATENCY slots to hide the
// external adder latency, then merges the slots and emits one summed vector per sequence.
module fp_vector_accumulator #(
  parameter int unsigned EXP_BITS    = 5,
  parameter int unsigned MANT_BITS   = 6,
  parameter int unsigned LANES       = 4,
  parameter int unsigned ADD_LATENCY = 2,
  parameter int unsigned CNT_BITS    = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [LANES*(1+EXP_BITS+MANT_BITS)-1:0] in_vec,
  input  logic                                   in_last,
  output logic                                   add_valid,
  output logic [LANES*(1+EXP_BITS+MANT_BITS)-1:0] add_a,
  output logic [LANES*(1+EXP_BITS+MANT_BITS)-1:0] add_b,
  input  logic                                   add_res_valid,
  input  logic [LANES*(1+EXP_BITS+MANT_BITS)-1:0] add_res,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANES*(1+EXP_BITS+MANT_BITS)-1:0] out_vec,
  output logic [CNT_BITS-1:0]                    out_count
);
  localparam int unsigned W  = 1 + EXP_BITS + MANT_BITS;
  localparam int unsigned VW = LANES * W;
  localparam int unsigned PW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

  typedef enum logic [2:0] {StIdle, StAccum, StDrain, StMerge, StOut} state_e;

  state_e                 state_q;
  logic [VW-1:0]          slot_q [ADD_LATENCY];
  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          merge_idx_q;
  logic                   merge_wait_q;
  logic [CNT_BITS-1:0]    count_q;
  logic [ADD_LATENCY-1:0] tag_vld_q;
  logic [PW-1:0]          tag_slot_q [ADD_LATENCY];

  logic          accept;
  logic          merge_issue;
  logic          capture;
  logic [PW-1:0] cap_slot;
  logic          fwd;
  logic          pending;

  assign in_ready    = (state_q == StIdle) || (state_q == StAccum);
  assign accept      = in_valid && in_ready;
  assign merge_issue = (state_q == StMerge) && !merge_wait_q;
  assign capture     = add_res_valid && tag_vld_q[ADD_LATENCY-1];
  assign cap_slot    = tag_slot_q[ADD_LATENCY-1];
  assign fwd         = capture && (cap_slot == ptr_q);

  // Entries still in flight besides the one returning this cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < int'(ADD_LATENCY) - 1; i++) begin
      pending = pending | tag_vld_q[i];
    end
  end

  always_comb begin
    add_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    if (accept) begin
      add_valid = 1'b1;
      add_a     = fwd ? add_res : slot_q[ptr_q];
      add_b     = in_vec;
    end else if (merge_issue) begin
      add_valid = 1'b1;
      add_a     = slot_q[0];
      add_b     = slot_q[merge_idx_q];
    end
  end

  assign out_valid = (state_q == StOut);
  assign out_vec   = out_valid ? slot_q[0] : '0;
  assign out_count = out_valid ? count_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      merge_idx_q  <= '0;
      merge_wait_q <= 1'b0;
      count_q      <= '0;
      tag_vld_q    <= '0;
      for (int i = 0; i < int'(ADD_LATENCY); i++) begin
        slot_q[i]     <= '0;
        tag_slot_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0]  <= accept || merge_issue;
      tag_slot_q[0] <= accept ? ptr_q : '0;
      for (int i = 1; i < int'(ADD_LATENCY); i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_slot_q[i] <= tag_slot_q[i-1];
      end
      if (capture) slot_q[cap_slot] <= add_res;

      case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            ptr_q <= (ptr_q == PW'(ADD_LATENCY - 1)) ? '0 : ptr_q + 1'b1;
            if (count_q != '1) count_q <= count_q + 1'b1;
            state_q <= in_last ? StDrain : StAccum;
          end
        end
        StDrain: begin
          if (!pending) begin
            if (ADD_LATENCY == 1) begin
              state_q <= StOut;
            end else begin
              state_q      <= StMerge;
              merge_idx_q  <= PW'(1);
              merge_wait_q <= 1'b0;
            end
          end
        end
        StMerge: begin
          if (merge_issue) begin
            merge_wait_q <= 1'b1;
          end else if (!pending) begin
            // Result for slot 0 is captured this cycle.
            if (merge_idx_q == PW'(ADD_LATENCY - 1)) begin
              state_q <= StOut;
            end else begin
              merge_idx_q  <= merge_idx_q + 1'b1;
              merge_wait_q <= 1'b0;
            end
          end
        end
        StOut: begin
          if (out_ready) begin
            for (int i = 0; i < int'(ADD_LATENCY); i++) slot_q[i] <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
